// File: rtl/pll_rst_pkg.sv
// Shared types and constants for the PLL reset/lock sequencer.
//   state_t       : sequencer states, one-hot encoded
//   RETRY_W       : width of the retry (lock timeout) counter
//   LOSS_CNT_W    : width of the lock-loss event counter
//   LOSS_CNT_MAX  : saturation value of the lock-loss counter
package pll_rst_pkg;

   typedef enum logic [4:0] {
      PLL_RST   = 5'b00001,
      WAIT_LOCK = 5'b00010,
      STABLE    = 5'b00100,
      RUN       = 5'b01000,
      FAULT     = 5'b10000
   } state_t;

   localparam int RETRY_W    = 4;
   localparam int LOSS_CNT_W = 8;
   localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = 8'd255;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for level signals entering the local clock domain.
// Ports:
//   clk : destination clock
//   rst : asynchronous, active-high reset; both stages clear to 0
//   d   : asynchronous input
//   q   : synchronised output, two clk edges behind d
module sync_2ff #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset and lock sequencer. Pulses the PLL reset, waits for lock, requires
// lock to stay stable before releasing the system reset, detects lock loss,
// retries on lock timeout and enters a sticky FAULT after repeated timeouts.
// Ports:
//   clkin         : 50 MHz reference clock (same clock that feeds the PLL)
//   reset         : asynchronous, active-high reset
//   lock          : PLL lock, asynchronous, synchronised internally
//   restart       : single-cycle pulse, leaves FAULT (ignored elsewhere)
//   pll_reset     : PLL reset input, active-high
//   sys_reset     : system reset for downstream logic, active-high, clkin domain
//   ready         : high only in RUN
//   fault         : high only in FAULT
//   retry_cnt     : lock timeouts seen during the current bring-up
//   lock_loss_cnt : lock losses seen while in RUN, saturating
module pll_reset_ctrl
   import pll_rst_pkg::*;
#(
   parameter int RST_PULSE_CYC    = 16,
   parameter int LOCK_TIMEOUT_CYC = 50000,
   parameter int LOCK_STABLE_CYC  = 1024,
   parameter int MAX_RETRIES      = 4,
   parameter int CNT_W            = 16
) (
   input  logic                  clkin,
   input  logic                  reset,
   input  logic                  lock,
   input  logic                  restart,
   output logic                  pll_reset,
   output logic                  sys_reset,
   output logic                  ready,
   output logic                  fault,
   output logic [RETRY_W-1:0]    retry_cnt,
   output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

   localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_PULSE_CYC - 1);
   localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
   localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q;
   logic [RETRY_W-1:0]      retry_d;
   logic [LOSS_CNT_W-1:0]   loss_d;
   logic                    lock_s;

   sync_2ff #(.W(1)) u_lock_sync (
      .clk (clkin),
      .rst (reset),
      .d   (lock),
      .q   (lock_s)
   );

   // Next state and next counter values. Lock events take priority over the
   // counter expiring in both WAIT_LOCK and STABLE.
   always_comb begin
      state_d = state_q;
      retry_d = retry_cnt;
      loss_d  = lock_loss_cnt;
      unique case (state_q)
         PLL_RST: begin
            if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (lock_s) begin
               state_d = STABLE;
            end else if (cnt_q == TIMEOUT_LAST) begin
               retry_d = retry_cnt + 1'b1;
               state_d = (retry_d == RETRY_LIMIT) ? FAULT : PLL_RST;
            end
         end
         STABLE: begin
            if (!lock_s) begin
               state_d = WAIT_LOCK;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = RUN;
               retry_d = '0;
            end
         end
         RUN: begin
            if (!lock_s) begin
               state_d = PLL_RST;
               if (lock_loss_cnt != LOSS_CNT_MAX) loss_d = lock_loss_cnt + 1'b1;
            end
         end
         FAULT: begin
            if (restart) begin
               state_d = PLL_RST;
               retry_d = '0;
            end
         end
         default: state_d = PLL_RST;
      endcase
   end

   // State, counter and outputs share one register stage; outputs decode the
   // next state so they move on the same edge as the transition.
   always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
         state_q       <= PLL_RST;
         cnt_q         <= '0;
         pll_reset     <= 1'b1;
         sys_reset     <= 1'b1;
         ready         <= 1'b0;
         fault         <= 1'b0;
         retry_cnt     <= '0;
         lock_loss_cnt <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= (state_d != state_q) ? '0 : cnt_q + 1'b1;
         pll_reset     <= (state_d == PLL_RST) || (state_d == FAULT);
         sys_reset     <= (state_d != RUN);
         ready         <= (state_d == RUN);
         fault         <= (state_d == FAULT);
         retry_cnt     <= retry_d;
         lock_loss_cnt <= loss_d;
      end
   end

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Bench for pll_reset_ctrl with short timing parameters. Each scenario starts
// from a reset; stimulus pushes the expected output vector and the edge number
// at which it must appear, and a monitor pops one entry whenever the outputs
// change.
module tb_pll_reset_ctrl;

   logic       clkin = 1'b0;
   logic       reset = 1'b1;
   logic       lock = 1'b0;
   logic       restart = 1'b0;
   logic       pll_reset, sys_reset, ready, fault;
   logic [3:0] retry_cnt;
   logic [7:0] lock_loss_cnt;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // {edge[15:0], pll_reset, sys_reset, ready, fault, retry_cnt, lock_loss_cnt}
   logic [31:0] exp_q[$];
   logic [15:0] prev_v = 16'hC000;

   localparam logic [15:0] RST_V = 16'hC000;

   pll_reset_ctrl #(
      .RST_PULSE_CYC    (4),
      .LOCK_TIMEOUT_CYC (20),
      .LOCK_STABLE_CYC  (8),
      .MAX_RETRIES      (2),
      .CNT_W            (16)
   ) dut (
      .clkin         (clkin),
      .reset         (reset),
      .lock          (lock),
      .restart       (restart),
      .pll_reset     (pll_reset),
      .sys_reset     (sys_reset),
      .ready         (ready),
      .fault         (fault),
      .retry_cnt     (retry_cnt),
      .lock_loss_cnt (lock_loss_cnt)
   );

   // ---------------- clock / reset-relative edge counter ----------------
   always #10 clkin = ~clkin;

   always @(posedge clkin or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   function automatic logic [15:0] vec(input logic p, input logic s, input logic r,
                                       input logic f, input logic [3:0] rc,
                                       input logic [7:0] lc);
      return {p, s, r, f, rc, lc};
   endfunction

   function automatic logic [15:0] cur_v();
      return {pll_reset, sys_reset, ready, fault, retry_cnt, lock_loss_cnt};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic push(input int c, input logic [15:0] v);
      logic [31:0] w;
      w = {c[15:0], v};
      exp_q.push_back(w);
   endtask

   // Returns 1 ns after edge e (edge 1 is the first edge after reset release).
   task automatic go_to(input int e);
      while (cyc < e) begin
         @(posedge clkin);
         #1;
      end
   endtask

   task automatic check_now(input string name, input logic [15:0] req);
      checks++;
      if (cur_v() !== req) begin
         errors++;
         $display("FAIL %s: outputs %h required %h", name, cur_v(), req);
      end
   endtask

   task automatic do_reset(input logic lk);
      lock    = lk;
      restart = 1'b0;
      @(posedge clkin);
      #3 reset = 1'b1;
      @(posedge clkin);
      #1 check_now("reset_values", RST_V);
      @(posedge clkin);
      #1 reset = 1'b0;
   endtask

   task automatic end_scn(input string name, input int last);
      go_to(last + 2);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_pending: %0d expected transitions not seen, required 0",
                  name, exp_q.size());
         exp_q.delete();
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clkin) begin
      logic [15:0] v;
      logic [31:0] e;
      if (reset) begin
         prev_v = RST_V;
      end else begin
         v = cur_v();
         if (v !== prev_v) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_change: edge %0d outputs %h, required no change from %h",
                        cyc, v, prev_v);
            end else begin
               e = exp_q.pop_front();
               if ({cyc[15:0], v} !== e) begin
                  errors++;
                  $display("FAIL transition: edge %0d outputs %h, required edge %0d outputs %h",
                           cyc, v, e[31:16], e[15:0]);
               end
            end
            prev_v = v;
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      errors++;
      $display("FAIL watchdog: time limit reached, required scenario completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // ---------------- stimulus ----------------
   initial begin
      int t;
      int lc;

      // Nominal bring-up with lock already high.
      do_reset(1'b1);
      push(4,  vec(0, 1, 0, 0, 4'd0, 8'd0));
      push(13, vec(0, 0, 1, 0, 4'd0, 8'd0));
      end_scn("nominal", 13);

      // Timeout to FAULT, restart, restart ignored outside FAULT.
      do_reset(1'b0);
      push(4,  vec(0, 1, 0, 0, 4'd0, 8'd0));
      push(24, vec(1, 1, 0, 0, 4'd1, 8'd0));
      push(28, vec(0, 1, 0, 0, 4'd1, 8'd0));
      push(48, vec(1, 1, 0, 1, 4'd2, 8'd0));
      push(56, vec(1, 1, 0, 0, 4'd0, 8'd0));
      push(60, vec(0, 1, 0, 0, 4'd0, 8'd0));
      go_to(55); restart = 1'b1;
      go_to(56); restart = 1'b0;
      go_to(64); restart = 1'b1;
      go_to(65); restart = 1'b0;
      end_scn("timeout_fault", 70);

      // Lock drops at STABLE cnt=5, then comes back.
      do_reset(1'b0);
      push(4,  vec(0, 1, 0, 0, 4'd0, 8'd0));
      push(27, vec(0, 0, 1, 0, 4'd0, 8'd0));
      go_to(6);  lock = 1'b1;
      go_to(12); lock = 1'b0;
      go_to(16); lock = 1'b1;
      end_scn("stable_abort", 27);

      // Lock loss in RUN and recovery.
      do_reset(1'b1);
      push(4,  vec(0, 1, 0, 0, 4'd0, 8'd0));
      push(13, vec(0, 0, 1, 0, 4'd0, 8'd0));
      push(23, vec(1, 1, 0, 0, 4'd0, 8'd1));
      push(27, vec(0, 1, 0, 0, 4'd0, 8'd1));
      push(36, vec(0, 0, 1, 0, 4'd0, 8'd1));
      go_to(20); lock = 1'b0;
      go_to(23); lock = 1'b1;
      end_scn("lock_loss", 36);

      // lock_s rises on the WAIT_LOCK timeout cycle: lock wins.
      do_reset(1'b0);
      push(4,  vec(0, 1, 0, 0, 4'd0, 8'd0));
      push(32, vec(0, 0, 1, 0, 4'd0, 8'd0));
      go_to(21); lock = 1'b1;
      end_scn("lock_on_timeout", 32);

      // lock_s falls on the final STABLE cycle: drop wins; then saturation.
      do_reset(1'b1);
      push(4,  vec(0, 1, 0, 0, 4'd0, 8'd0));
      push(24, vec(0, 0, 1, 0, 4'd0, 8'd0));
      go_to(10); lock = 1'b0;
      go_to(13); lock = 1'b1;
      go_to(24);
      t = 24;
      for (int i = 1; i <= 260; i++) begin
         lc = (i > 255) ? 255 : i;
         push(t + 3,  vec(1, 1, 0, 0, 4'd0, 8'(lc)));
         push(t + 7,  vec(0, 1, 0, 0, 4'd0, 8'(lc)));
         push(t + 16, vec(0, 0, 1, 0, 4'd0, 8'(lc)));
         lock = 1'b0;
         go_to(t + 3);
         lock = 1'b1;
         go_to(t + 16);
         t = t + 16;
      end
      end_scn("drop_final_and_saturation", t);
      check_now("loss_saturated", vec(0, 0, 1, 0, 4'd0, 8'd255));

      // Asynchronous reset between edges while in RUN.
      @(posedge clkin);
      #5 reset = 1'b1;
      #1 check_now("async_reset_mid_run", RST_V);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pll_reset_ctrl.md
Name: pll_reset_ctrl

Overview:
Reset and lock sequencer that sits directly alongside the gw_pll instance, driving its reset input and consuming its lock output.
- Runs on the 50 MHz board reference clock, the same clock that feeds the PLL.
- Pulses the PLL reset, waits for lock, and requires lock to stay stable before releasing the system reset used by the camera/tracker pipeline.
- Detects lock loss, retries on lock timeout, and flags a sticky fault after repeated failures.

Parameters:
RST_PULSE_CYC, 16, clkin cycles that pll_reset is held high per attempt (>=2).
LOCK_TIMEOUT_CYC, 50000, clkin cycles to wait for lock per attempt (1 ms at 50 MHz).
LOCK_STABLE_CYC, 1024, consecutive synchronised-lock-high cycles required before release.
MAX_RETRIES, 4, timeouts allowed before entering FAULT (1..15).
CNT_W, 16, shared cycle-counter width; must hold max(all *_CYC) - 1.

Ports:
clkin  in  1  50 MHz reference clock; single clock domain.
reset  in  1  asynchronous, active-high reset.
lock  in  1  PLL lock; asynchronous to clkin and synchronised internally.
restart  in  1  single-cycle pulse that leaves FAULT; ignored in every other state.
pll_reset  out  1  drives the PLL reset input, active-high.
sys_reset  out  1  system reset, active-high, in the clkin domain.
ready  out  1  high only in RUN.
fault  out  1  high only in FAULT.
retry_cnt  out  4  number of timeouts in the current bring-up.
lock_loss_cnt  out  8  number of RUN-to-lock-loss events; saturates at 255.

Behaviour:
- Reset is one clock, asynchronous, active-high.
- Reset values: state=PLL_RST, cnt=0, pll_reset=1, sys_reset=1, ready=0, fault=0, retry_cnt=0, lock_loss_cnt=0, sync flops=0.
- lock passes through a 2-flop synchroniser to give lock_s (2 clkin edges of latency).
- All outputs are registered and decoded from the next state, so they change on the same edge as the transition.
- cnt clears on every state change and increments on every other cycle.
- PLL_RST: pll_reset=1, sys_reset=1. When cnt==RST_PULSE_CYC-1, go to WAIT_LOCK.
- WAIT_LOCK: pll_reset=0, sys_reset=1.
  - lock_s=1: go to STABLE.
  - Otherwise, when cnt==LOCK_TIMEOUT_CYC-1: retry_cnt+1. If the new value equals MAX_RETRIES, go to FAULT; else go to PLL_RST.
- STABLE: pll_reset=0, sys_reset=1.
  - lock_s=0: go to WAIT_LOCK with a fresh timeout and no retry increment.
  - lock_s=1 and cnt==LOCK_STABLE_CYC-1: go to RUN and clear retry_cnt.
- RUN: pll_reset=0, sys_reset=0, ready=1.
  - lock_s=0: lock_loss_cnt+1 (saturating), go to PLL_RST.
  - sys_reset reasserts 3 clkin edges after lock falls (2 synchroniser edges plus 1).
- FAULT: pll_reset=1 (PLL held off), sys_reset=1, fault=1.
  - Sticky until reset, or until restart=1, which clears retry_cnt and goes to PLL_RST.
- Simultaneous events:
  - In WAIT_LOCK, lock_s=1 on the timeout cycle: lock wins, go to STABLE.
  - In STABLE, lock_s=0 on the final cycle: drop wins, go to WAIT_LOCK.
- lock_loss_cnt clears only on reset; restart does not clear it.
- Nominal release latency with lock already high: sys_reset falls on edge RST_PULSE_CYC+1+LOCK_STABLE_CYC after reset deassertion.
- reset asserted mid-operation immediately forces all reset values, including pll_reset=1.
- sys_reset is clkin-domain only; each consuming clkout-domain block re-synchronises it.
- Glitches on lock shorter than one clkin period may be missed; this is accepted.

Decomposition:
- pll_rst_pkg holds:
  - state enum: PLL_RST, WAIT_LOCK, STABLE, RUN, FAULT (one-hot encoding preferred);
  - LOSS_CNT_MAX=255;
  - retry counter width 4.
- One sub-module, sync_2ff: parameterised-width 2-flop synchroniser with asynchronous reset to 0, used for lock.
- Everything else (FSM, cnt, output registers) lives in pll_reset_ctrl.

Test Plan:
Bench parameters: RST_PULSE_CYC=4, LOCK_TIMEOUT_CYC=20, LOCK_STABLE_CYC=8, MAX_RETRIES=2.
- Nominal: lock=1 from the start, reset released -> pll_reset falls after edge 4; sys_reset falls and ready rises after edge 13; retry_cnt=0.
- Timeout to fault: lock held 0 -> retry_cnt=1 after edge 24; two pll_reset pulses total; fault=1 and pll_reset=1 after edge 48; then a restart pulse -> state PLL_RST, retry_cnt=0, fault=0.
- Stability abort: lock rises, then drops at STABLE cnt=5 -> returns to WAIT_LOCK, sys_reset stays 1, retry_cnt unchanged; lock high again -> sys_reset releases after 8 further stable cycles.
- Lock loss in RUN: drop lock -> sys_reset=1 three edges later; lock_loss_cnt=1; pll_reset pulses 4 cycles; recovery to RUN.
- Simultaneity and saturation: lock_s rises exactly on the timeout cycle -> STABLE, no increment; 260 forced lock losses -> lock_loss_cnt=255.
- Async reset asserted mid-RUN between clock edges -> pll_reset=1, sys_reset=1, ready=0 before the next edge.
